// File: rtl/mario_frame_renderer.sv
// Per-pixel scene lookup: tracks the background tile under each raster pixel and
// tests it against a frame-latched Mario box, with a fixed two-cycle pipeline.
module mario_frame_renderer #(
  parameter int BDR              = 0,
  parameter int CHARACTER_WIDTH  = 42,
  parameter int CHARACTER_HEIGHT = 42,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int BLOCK_WIDTH      = 40
) (
  input  logic                      vga_clock,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      pixel_active,
  input  logic [9:0]                pixel_x,
  input  logic [9:0]                pixel_y,
  input  logic signed [31:0]        mario_x,
  input  logic signed [31:0]        mario_y,
  input  logic [11:0][16:0][7:0]    background,
  output logic                      out_valid,
  output logic [7:0]                tile_code,
  output logic [5:0]                tile_u,
  output logic [5:0]                tile_v,
  output logic                      sprite_hit,
  output logic [5:0]                sprite_u,
  output logic [5:0]                sprite_v
);

  localparam int PW = $clog2((SCREEN_WIDTH > SCREEN_HEIGHT) ? SCREEN_WIDTH : SCREEN_HEIGHT);
  localparam int MAP_ROWS = 12;
  localparam int MAP_COLS = 17;
  localparam logic [5:0] U_LAST = 6'(BLOCK_WIDTH - 1);

  logic signed [31:0] mx_s_q, my_s_q;
  logic [5:0]         u_q, v_q, u_cur, v_cur;
  logic [4:0]         col_q, row_q, col_cur, row_cur;

  logic               vld_p1_q;
  logic [4:0]         col_p1_q, row_p1_q;
  logic [5:0]         u_p1_q, v_p1_q;
  logic signed [31:0] dx_p1_q, dy_p1_q;
  logic signed [31:0] dx_d, dy_d;

  logic [7:0]         code_d;
  logic               hit_d;

  // u_q/col_q hold the position of the next pixel on the line; v_q/row_q hold the current line.
  always_comb begin
    u_cur   = u_q;
    col_cur = col_q;
    v_cur   = v_q;
    row_cur = row_q;
    if (pixel_x == '0) begin
      u_cur   = '0;
      col_cur = '0;
      if (pixel_y == '0) begin
        v_cur   = '0;
        row_cur = '0;
      end else if (v_q == U_LAST) begin
        v_cur   = '0;
        row_cur = row_q + 5'd1;
      end else begin
        v_cur   = v_q + 6'd1;
      end
    end
  end

  assign dx_d = $signed({{(32-PW){1'b0}}, pixel_x[PW-1:0]}) - mx_s_q;
  assign dy_d = $signed({{(32-PW){1'b0}}, pixel_y[PW-1:0]}) - my_s_q;

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      mx_s_q <= '0;
      my_s_q <= '0;
      u_q    <= '0;
      v_q    <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      if (frame_start) begin
        mx_s_q <= mario_x;
        my_s_q <= mario_y;
      end
      if (pixel_active) begin
        if (u_cur == U_LAST) begin
          u_q   <= '0;
          col_q <= col_cur + 5'd1;
        end else begin
          u_q   <= u_cur + 6'd1;
          col_q <= col_cur;
        end
        v_q   <= v_cur;
        row_q <= row_cur;
      end
    end
  end

  // Stage 1: capture tile position and signed sprite-relative deltas
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      col_p1_q <= '0;
      row_p1_q <= '0;
      u_p1_q   <= '0;
      v_p1_q   <= '0;
      dx_p1_q  <= '0;
      dy_p1_q  <= '0;
    end else begin
      vld_p1_q <= pixel_active;
      col_p1_q <= col_cur;
      row_p1_q <= row_cur;
      u_p1_q   <= u_cur;
      v_p1_q   <= v_cur;
      dx_p1_q  <= dx_d;
      dy_p1_q  <= dy_d;
    end
  end

  always_comb begin
    code_d = 8'(BDR);
    if (row_p1_q < 5'(MAP_ROWS) && col_p1_q < 5'(MAP_COLS))
      code_d = background[row_p1_q[3:0]][col_p1_q];
    hit_d = (dx_p1_q >= 0) && (dx_p1_q < CHARACTER_WIDTH) &&
            (dy_p1_q >= 0) && (dy_p1_q < CHARACTER_HEIGHT);
  end

  // Stage 2: map lookup and sprite box test; everything is zero when not valid
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      tile_code  <= '0;
      tile_u     <= '0;
      tile_v     <= '0;
      sprite_hit <= 1'b0;
      sprite_u   <= '0;
      sprite_v   <= '0;
    end else begin
      out_valid  <= vld_p1_q;
      tile_code  <= vld_p1_q ? code_d : 8'd0;
      tile_u     <= vld_p1_q ? u_p1_q : 6'd0;
      tile_v     <= vld_p1_q ? v_p1_q : 6'd0;
      sprite_hit <= vld_p1_q && hit_d;
      sprite_u   <= (vld_p1_q && hit_d) ? dx_p1_q[5:0] : 6'd0;
      sprite_v   <= (vld_p1_q && hit_d) ? dy_p1_q[5:0] : 6'd0;
    end
  end

endmodule

// File: tb/tb_mario_frame_renderer.sv
// Randomised raster bench for mario_frame_renderer against a division-based scene model.
module tb_mario_frame_renderer;
  localparam int SKY = 1;

  logic clk = 1'b0, rst = 1'b1, fs = 1'b0, act = 1'b0;
  logic [9:0] px = '0, py = '0;
  logic signed [31:0] mx = 0, my = 0;
  logic [11:0][16:0][7:0] bg;
  logic out_valid, sprite_hit;
  logic [7:0] tile_code;
  logic [5:0] tile_u, tile_v, sprite_u, sprite_v;
  int errors = 0, checks = 0;
  int fid = 0;

  mario_frame_renderer dut (
    .vga_clock(clk), .reset(rst), .frame_start(fs), .pixel_active(act),
    .pixel_x(px), .pixel_y(py), .mario_x(mx), .mario_y(my), .background(bg),
    .out_valid(out_valid), .tile_code(tile_code), .tile_u(tile_u), .tile_v(tile_v),
    .sprite_hit(sprite_hit), .sprite_u(sprite_u), .sprite_v(sprite_v)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [7:0] code; logic [5:0] tu; logic [5:0] tv;
    logic hit; logic [5:0] su; logic [5:0] sv; int fid; int x; int y;
  } exp_t;

  exp_t p1, p2;
  int smx = 0, smy = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: actual=%h required=%h", nm, a, e);
    end
  endtask

  // Reference: tile = coordinate / 40, texel = coordinate % 40, sprite box from frame-latched position
  always @(posedge clk) begin
    exp_t n;
    int r, c, dx, dy;
    n = '0;
    if (rst) begin
      p1 = '0; p2 = '0; smx = 0; smy = 0;
    end else begin
      if (act) begin
        c = int'(px) / 40;
        r = int'(py) / 40;
        n.v  = 1'b1;
        n.tu = 6'(int'(px) % 40);
        n.tv = 6'(int'(py) % 40);
        n.code = (r <= 11 && c <= 16) ? bg[r][c] : 8'd0;
        dx = int'(px) - smx;
        dy = int'(py) - smy;
        if (dx >= 0 && dx < 42 && dy >= 0 && dy < 42) begin
          n.hit = 1'b1; n.su = 6'(dx); n.sv = 6'(dy);
        end
        n.fid = fid; n.x = int'(px); n.y = int'(py);
      end
      if (fs) begin
        smx = mx; smy = my;
      end
      p2 = p1;
      p1 = n;
    end
  end

  task automatic lit(input int f, input int x, input int y);
    if (f == 1 && x == 5   && y == 39)  chk("row39",     {tile_code, tile_u, tile_v}, {8'd9, 6'd5, 6'd39});
    if (f == 1 && x == 5   && y == 40)  chk("row40_sky", {tile_code, tile_v}, {8'(SKY), 6'd0});
    if (f == 1 && x == 45  && y == 40)  chk("row40_c1",  {tile_code, tile_u}, {8'd9, 6'd5});
    if (f == 1 && x == 0   && y == 460) chk("clip_left", {sprite_hit, sprite_u, sprite_v}, {1'b1, 6'd10, 6'd0});
    if (f == 1 && x == 31  && y == 460) chk("clip_x31",  {sprite_hit, sprite_u}, {1'b1, 6'd41});
    if (f == 1 && x == 32  && y == 460) chk("clip_x32",  {sprite_hit, sprite_u}, {1'b0, 6'd0});
    if (f == 1 && x == 0   && y == 459) chk("clip_y459", {sprite_hit}, {1'b0});
    if (f == 1 && x == 31  && y == 479) chk("clip_y479", {sprite_hit, sprite_v}, {1'b1, 6'd19});
    if (f == 1 && x == 639 && y == 479) chk("corner",    {sprite_hit, tile_code, tile_u, tile_v}, {1'b0, 8'd9, 6'd39, 6'd39});
    if (f == 2 && x == 0   && y == 0)   chk("walk_x0",   {tile_code, tile_u}, {8'd0, 6'd0});
    if (f == 2 && x == 39  && y == 0)   chk("walk_x39",  {tile_code, tile_u}, {8'd0, 6'd39});
    if (f == 2 && x == 40  && y == 0)   chk("walk_x40",  {tile_code, tile_u}, {8'd1, 6'd0});
    if (f == 2 && x == 639 && y == 0)   chk("walk_x639", {tile_code, tile_u}, {8'd15, 6'd39});
    if (f == 2 && x == 100 && y == 200) chk("box_tl",    {sprite_hit, sprite_u, sprite_v}, {1'b1, 6'd0, 6'd0});
    if (f == 2 && x == 99  && y == 200) chk("box_x99",   {sprite_hit}, {1'b0});
    if (f == 2 && x == 142 && y == 200) chk("box_x142",  {sprite_hit}, {1'b0});
    if (f == 2 && x == 141 && y == 241) chk("box_br",    {sprite_hit, sprite_u, sprite_v}, {1'b1, 6'd41, 6'd41});
    if (f == 2 && x == 100 && y == 242) chk("box_y242",  {sprite_hit}, {1'b0});
    if (f == 2 && x == 300 && y == 241) chk("latch_mid", {sprite_hit}, {1'b0});
    if (f == 3 && x == 0   && y == 0)   chk("fs_same_px",{sprite_hit}, {1'b0});
    if (f == 3 && x == 1   && y == 0)   chk("fs_next_px",{sprite_hit, sprite_u, sprite_v}, {1'b1, 6'd2, 6'd0});
    if (f == 3 && x == 40  && y == 0)   chk("fs_x40",    {sprite_hit, sprite_u}, {1'b1, 6'd41});
    if (f == 3 && x == 41  && y == 0)   chk("fs_x41",    {sprite_hit}, {1'b0});
  endtask

  always @(negedge clk) begin
    exp_t e;
    e = rst ? '0 : p2;
    chk($sformatf("pix f%0d (%0d,%0d)", e.fid, e.x, e.y),
        {out_valid, tile_code, tile_u, tile_v, sprite_hit, sprite_u, sprite_v},
        {e.v, e.code, e.tu, e.tv, e.hit, e.su, e.sv});
    if (!rst && e.v) lit(e.fid, e.x, e.y);
  end

  task automatic step(input logic a, input int x, input int y, input logic f);
    act = a; px = 10'(x); py = 10'(y); fs = f;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0);
  endtask

  function automatic bit wide(input int f, input int y);
    case (f)
      1: return y inside {0, 39, 40, 459, 460, 479};
      2: return y inside {0, 200, 241, 242};
      default: return y == 0;
    endcase
  endfunction

  task automatic frame(input int f, input int nl, input bit coincide, input int chg_line, input int chg_x);
    fid = f;
    if (!coincide) step(1'b0, 0, 0, 1'b1);
    for (int y = 0; y < nl; y++) begin
      int w;
      if (y == chg_line) mx = chg_x;
      w = wide(f, y) ? 640 : int'($urandom_range(1, 48));
      for (int x = 0; x < w; x++) begin
        if ($urandom_range(0, 7) == 0) step(1'b0, int'($urandom_range(0, 1023)), y, 1'b0);
        step(1'b1, x, y, coincide && x == 0 && y == 0);
      end
      idle(1);
    end
  endtask

  initial begin
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++) bg[r][c] = 8'd9;
    bg[1][0] = 8'(SKY);
    mx = -10; my = 460;

    for (int x = 0; x < 8; x++) step(1'b1, x, 0, x == 0);
    chk("reset_state", {out_valid, tile_code, tile_u, tile_v, sprite_hit, sprite_u, sprite_v}, 64'd0);
    act = 1'b0;
    rst = 1'b0;
    idle(3);

    frame(1, 480, 1'b0, -1, 0);

    idle(3);
    for (int c = 0; c < 17; c++) bg[0][c] = 8'(c);
    mx = 100; my = 200;
    frame(2, 480, 1'b0, 220, 300);

    idle(3);
    mx = -1; my = 0;
    frame(3, 10, 1'b1, -1, 0);

    idle(3);
    fid = 4;
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 1, 0, 1'b0);
    chk("pre_reset", {out_valid, sprite_hit}, {1'b1, 1'b1});
    #2 rst = 1'b1;
    #1 chk("async_reset", {out_valid, tile_code, tile_u, tile_v, sprite_hit, sprite_u, sprite_v}, 64'd0);
    act = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mario_frame_renderer.md
# mario_frame_renderer

Per-pixel scene lookup stage on the VGA side of the game. It consumes the raster pixel stream from the VGA timing generator, the 12x17 background tile map, and the Mario position published by the movement logic. For every active pixel it produces the tile code and in-tile texel coordinates, plus a Mario sprite hit flag with sprite texel coordinates, for the downstream colour mapper. Mario position is sampled once per frame so the sprite never tears mid-frame.

## Interface
- BDR, 0: border tile code; returned for off-map tiles
- SKY, 1: sky tile code; used in the test plan only
- CHARACTER_WIDTH, 42: Mario sprite width in pixels
- CHARACTER_HEIGHT, 42: Mario sprite height in pixels
- SCREEN_WIDTH, 640: active pixels per line
- SCREEN_HEIGHT, 480: active lines per frame
- BLOCK_WIDTH, 40: tile edge in pixels, square tiles

Ports:
- vga_clock  in  1  pixel clock; the single clock
- reset  in  1  asynchronous, active-high
- frame_start  in  1  one-cycle pulse before the first active pixel of a frame
- pixel_active  in  1  pixel_x/pixel_y valid this cycle
- pixel_x  in  10  current column, 0..SCREEN_WIDTH-1
- pixel_y  in  10  current row, 0..SCREEN_HEIGHT-1
- mario_x  in  int  Mario top-left column, signed
- mario_y  in  int  Mario top-left row, signed
- background  in  byte [11:0][16:0]  tile map indexed [row][col]
- out_valid  out  1  outputs below describe one pixel
- tile_code  out  8  background tile code at pixel
- tile_u  out  6  column within tile, 0..BLOCK_WIDTH-1
- tile_v  out  6  row within tile, 0..BLOCK_WIDTH-1
- sprite_hit  out  1  pixel lies inside the Mario box
- sprite_u  out  6  column within sprite
- sprite_v  out  6  row within sprite

## Operation
- Shadow regs mx_s, my_s load mario_x, mario_y on each frame_start cycle. They hold for the rest of the frame. Mid-frame changes on mario_x/mario_y are ignored.
- Tile tracking uses incremental counters; there is no divider.
  - col_cnt/u_cnt: cleared on an active pixel with pixel_x==0. Otherwise they advance per active pixel: u_cnt increments and wraps BLOCK_WIDTH-1 -> 0, and col_cnt increments on each wrap.
  - row_cnt/v_cnt: update on an active pixel with pixel_x==0. If pixel_y==0, clear both. Otherwise v_cnt increments with the same wrap, and row_cnt increments on wrap.
  - The stream is raster-ordered and contiguous within a line. Gaps in pixel_active hold the counters.
- Stage 1 registers the inputs: valid, col/row/u/v, and the signed deltas dx=pixel_x-mx_s and dy=pixel_y-my_s.
  - Deltas are computed in 32-bit signed arithmetic, with pixel coordinates zero-extended.
- Stage 2 produces the outputs.
  - tile_code = background[row][col] when row<=11 and col<=16; else BDR.
  - sprite_hit = 0<=dx<CHARACTER_WIDTH and 0<=dy<CHARACTER_HEIGHT.
  - sprite_u = dx[5:0] and sprite_v = dy[5:0] when hit; otherwise 0.
  - tile_u/tile_v are passed through.
- Negative or off-screen Mario positions are legal; they clip naturally with no wrap artifacts.
- While out_valid is 0, all other outputs are 0.

## Timing
- Latency: 2 cycles. The pixel presented at cycle N appears with out_valid=1 at cycle N+2.
- Throughput: one pixel per clock, with no stall.
- frame_start and a pixel in the same cycle: that pixel uses the old shadow values. The new values apply from cycle +1.
- background is sampled combinationally in stage 2, so a map change is visible 0 cycles later on the following pixels.
- Reset, asserted at any time:
  - Immediately, with no clock needed: out_valid, tile_code, tile_u, tile_v, sprite_hit, sprite_u and sprite_v = 0.
  - mx_s, my_s and all counters = 0, and the pipeline is flushed.
  - After deassertion, out_valid is 0 for at least 2 cycles.
- Reset mid-frame: the counters resynchronise at the next pixel_x==0. Rows realign at the next pixel_y==0.

## Test plan
- **Reset state:** reset high with active pixels applied -> all outputs 0. Release, run line 0 -> first out_valid exactly 2 cycles after the first active pixel.
- **Tile walk:** background[0][c]=c, frame_start, then line 0 -> tile_code 0 for x 0..39 and 1 for x 40..79. tile_u wraps 39->0 at x=40. x=639 gives tile_code 15, tile_u 39.
- **Row advance:** background[1][0]=SKY, others 9 -> line 39 gives code 9 with tile_v 39. Line 40 gives code SKY with tile_v 0 at x 0..39.
- **Sprite box:** mario_x=100, mario_y=200 latched -> hit only for x 100..141 and y 200..241. At (100,200) u=0,v=0; at (141,241) u=41,v=41. At (142,200) hit=0.
- **Clipping:** mario_x=-10, mario_y=460 -> hit for x 0..31 and y 460..479. At (0,460) sprite_u=10. There are no hits at x>=600.
- **Frame latch:** change mario_x from 100 to 300 mid-frame -> hits stay at 100..141 until the next frame_start. A frame_start coincident with pixel (0,0) -> that pixel uses 100, and pixel (1,0) onward uses 300.
